// File: rtl/ball_collision_detector_pkg.sv
`default_nettype none
// ============================================================================
//  Package : defines_collision
//  Shared definitions for the ball collision detector: default pulse
//  holdoff lengths and identifiers for every collidable scene object.
//  Revision: 1.0 - initial release
// ============================================================================
package defines_collision;

    // Frames (counted by startOfFrame) that must pass after a pulse
    // before the same object may pulse again.
    localparam int c_SPRING_HOLDOFF_DEFAULT = 8;
    localparam int c_BUMPER_HOLDOFF_DEFAULT = 4;

    // Number of objects the ball can collide with.
    localparam int c_NUM_OBJ = 5;

    // Object identifiers; also used as bit positions in the hit vector.
    typedef enum logic [2:0] {
        OBJ_FLIPPER  = 3'd0,
        OBJ_OBSTACLE = 3'd1,
        OBJ_SPRING   = 3'd2,
        OBJ_BUMPER   = 3'd3,
        OBJ_FRAME    = 3'd4
    } collision_obj_e;

    // Holdoff counter width for a given holdoff length; never below 1 bit
    // so a zero holdoff still yields a legal vector.
    function automatic int holdoff_width(input int holdoff);
        int w;
        w = (holdoff > 0) ? $clog2(holdoff + 1) : 1;
        return (w < 1) ? 1 : w;
    endfunction

endpackage : defines_collision
`default_nettype wire

// File: rtl/ball_collision_detector_collision_channel.sv
`default_nettype none
// ============================================================================
//  Module  : collision_channel
//  One collision channel: a per-frame sticky flag and, when HAS_PULSE is
//  set, a rate-limited single-cycle pulse guarded by a frame holdoff
//  counter. The single output is the sticky level for plain channels and
//  the pulse for pulse channels.
//  Revision: 1.0 - initial release
// ============================================================================
module collision_channel
    import defines_collision::*;
#(
    parameter bit HAS_PULSE = 1'b0,
    parameter int HOLDOFF   = 0
) (
    input  logic clk,
    input  logic resetN,
    input  logic sof_i,
    input  logic pause_i,
    input  logic hit_i,
    output logic out_o
);

    logic flag_q;
    logic flag_d;

    // Sticky flag: a hit sets it, a new frame clears it, and a hit that
    // lands on the frame strobe belongs to the new frame so it still sets.
    // Pause discards everything.
    always_comb begin
        flag_d = flag_q;
        if (pause_i) begin
            flag_d = 1'b0;
        end else if (hit_i) begin
            flag_d = 1'b1;
        end else if (sof_i) begin
            flag_d = 1'b0;
        end
    end

    // Sticky flag register.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            flag_q <= 1'b0;
        end else begin
            flag_q <= flag_d;
        end
    end

    generate
        if (HAS_PULSE) begin : g_pulse
            localparam int c_CW = holdoff_width(HOLDOFF);

            logic [c_CW-1:0] holdoff_q;
            logic [c_CW-1:0] holdoff_d;
            logic            pulse_q;
            logic            pulse_d;
            logic            first_hit;
            logic            holdoff_idle;

            // A hit on the frame strobe opens a new frame, so the old
            // frame's flag must not suppress it.
            assign first_hit    = sof_i | ~flag_q;
            // Compared against the pre-decrement value on purpose: a hit
            // coincident with the strobe still sees the old count.
            assign holdoff_idle = (holdoff_q == '0);

            // Pulse decision and holdoff update; counter is frozen in pause
            // and saturates at zero.
            always_comb begin
                pulse_d   = hit_i & ~pause_i & first_hit & holdoff_idle;
                holdoff_d = holdoff_q;
                if (!pause_i) begin
                    if (pulse_d) begin
                        holdoff_d = c_CW'(HOLDOFF);
                    end else if (sof_i && !holdoff_idle) begin
                        holdoff_d = holdoff_q - c_CW'(1);
                    end
                end
            end

            // Pulse and holdoff registers; reset aborts any pending holdoff.
            always_ff @(posedge clk) begin
                if (!resetN) begin
                    pulse_q   <= 1'b0;
                    holdoff_q <= '0;
                end else begin
                    pulse_q   <= pulse_d;
                    holdoff_q <= holdoff_d;
                end
            end

            assign out_o = pulse_q;
        end else begin : g_level
            assign out_o = flag_q;
        end
    endgenerate

endmodule : collision_channel
`default_nettype wire

// File: rtl/ball_collision_detector.sv
`default_nettype none
// ============================================================================
//  Module  : ball_collision_detector
//  Detects ball/object pixel overlaps during the raster scan. Drives
//  sticky per-frame collision levels for flipper, obstacle and border, and
//  holdoff-limited single-cycle pulses for spring and bumper.
//  Revision: 1.0 - initial release
// ============================================================================
module ball_collision_detector
    import defines_collision::*;
#(
    parameter int SPRING_HOLDOFF_FRAMES = c_SPRING_HOLDOFF_DEFAULT,
    parameter int BUMPER_HOLDOFF_FRAMES = c_BUMPER_HOLDOFF_DEFAULT
) (
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic pause,
    input  logic draw_smiley,
    input  logic draw_flipper,
    input  logic draw_obstacle,
    input  logic draw_spring,
    input  logic draw_bumper,
    input  logic draw_frame,
    output logic collisionSmileyFlipper,
    output logic collisionSmileyObstacle,
    output logic collisionSmileyFrame,
    output logic collisionSmileySpringPulse,
    output logic collisionSmileyBumperPulse
);

    // One bit per object: ball and object drawn on the same pixel.
    logic [c_NUM_OBJ-1:0] w_hit;

    assign w_hit[OBJ_FLIPPER]  = draw_smiley & draw_flipper;
    assign w_hit[OBJ_OBSTACLE] = draw_smiley & draw_obstacle;
    assign w_hit[OBJ_SPRING]   = draw_smiley & draw_spring;
    assign w_hit[OBJ_BUMPER]   = draw_smiley & draw_bumper;
    assign w_hit[OBJ_FRAME]    = draw_smiley & draw_frame;

    collision_channel #(
        .HAS_PULSE (1'b0),
        .HOLDOFF   (0)
    ) u_flipper (
        .clk     (clk),
        .resetN  (resetN),
        .sof_i   (startOfFrame),
        .pause_i (pause),
        .hit_i   (w_hit[OBJ_FLIPPER]),
        .out_o   (collisionSmileyFlipper)
    );

    collision_channel #(
        .HAS_PULSE (1'b0),
        .HOLDOFF   (0)
    ) u_obstacle (
        .clk     (clk),
        .resetN  (resetN),
        .sof_i   (startOfFrame),
        .pause_i (pause),
        .hit_i   (w_hit[OBJ_OBSTACLE]),
        .out_o   (collisionSmileyObstacle)
    );

    collision_channel #(
        .HAS_PULSE (1'b1),
        .HOLDOFF   (SPRING_HOLDOFF_FRAMES)
    ) u_spring (
        .clk     (clk),
        .resetN  (resetN),
        .sof_i   (startOfFrame),
        .pause_i (pause),
        .hit_i   (w_hit[OBJ_SPRING]),
        .out_o   (collisionSmileySpringPulse)
    );

    collision_channel #(
        .HAS_PULSE (1'b1),
        .HOLDOFF   (BUMPER_HOLDOFF_FRAMES)
    ) u_bumper (
        .clk     (clk),
        .resetN  (resetN),
        .sof_i   (startOfFrame),
        .pause_i (pause),
        .hit_i   (w_hit[OBJ_BUMPER]),
        .out_o   (collisionSmileyBumperPulse)
    );

    collision_channel #(
        .HAS_PULSE (1'b0),
        .HOLDOFF   (0)
    ) u_frame (
        .clk     (clk),
        .resetN  (resetN),
        .sof_i   (startOfFrame),
        .pause_i (pause),
        .hit_i   (w_hit[OBJ_FRAME]),
        .out_o   (collisionSmileyFrame)
    );

endmodule : ball_collision_detector
`default_nettype wire

// File: tb/tb_ball_collision_detector.sv
`default_nettype none
// ============================================================================
//  Module  : tb_ball_collision_detector
//  Self-checking bench: stimulus drives the DUT and a frame-level reference
//  model, pushing the expected output vector into a queue; an independent
//  monitor pops and compares every cycle.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_ball_collision_detector;

    localparam int c_H_SPRING = 8;
    localparam int c_H_BUMPER = 4;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic startOfFrame = 1'b0;
    logic pause = 1'b0;
    logic draw_smiley = 1'b0;
    logic draw_flipper = 1'b0;
    logic draw_obstacle = 1'b0;
    logic draw_spring = 1'b0;
    logic draw_bumper = 1'b0;
    logic draw_frame = 1'b0;
    logic collisionSmileyFlipper;
    logic collisionSmileyObstacle;
    logic collisionSmileyFrame;
    logic collisionSmileySpringPulse;
    logic collisionSmileyBumperPulse;

    ball_collision_detector #(
        .SPRING_HOLDOFF_FRAMES (c_H_SPRING),
        .BUMPER_HOLDOFF_FRAMES (c_H_BUMPER)
    ) dut (
        .clk                        (clk),
        .resetN                     (resetN),
        .startOfFrame               (startOfFrame),
        .pause                      (pause),
        .draw_smiley                (draw_smiley),
        .draw_flipper               (draw_flipper),
        .draw_obstacle              (draw_obstacle),
        .draw_spring                (draw_spring),
        .draw_bumper                (draw_bumper),
        .draw_frame                 (draw_frame),
        .collisionSmileyFlipper     (collisionSmileyFlipper),
        .collisionSmileyObstacle    (collisionSmileyObstacle),
        .collisionSmileyFrame       (collisionSmileyFrame),
        .collisionSmileySpringPulse (collisionSmileySpringPulse),
        .collisionSmileyBumperPulse (collisionSmileyBumperPulse)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int spring_pulses = 0;
    int bumper_pulses = 0;

    // Expected output vector: {bumper, spring, frame, obstacle, flipper}.
    logic [4:0] exp_q[$];

    // Reference model state, kept at frame level: which objects were hit
    // this frame, how many unpaused frames have started, and the frame
    // index of each pulse object's most recent pulse.
    bit [4:0] m_seen = '0;
    int       m_frame = 0;
    bit       m_ever[2] = '{0, 0};
    int       m_last[2] = '{0, 0};
    int       m_hold[2] = '{c_H_SPRING, c_H_BUMPER};

    // Draw vector bits: [0] smiley, [1] flipper, [2] obstacle, [3] spring,
    // [4] bumper, [5] frame.
    task automatic tick(input logic [5:0] d, input logic sof, input logic pau, input logic rn);
        logic [4:0] e;
        bit [4:0]   hit;
        bit         first;
        bit         allowed;
        @(negedge clk);
        draw_smiley   = d[0];
        draw_flipper  = d[1];
        draw_obstacle = d[2];
        draw_spring   = d[3];
        draw_bumper   = d[4];
        draw_frame    = d[5];
        startOfFrame  = sof;
        pause         = pau;
        resetN        = rn;
        e = '0;
        if (!rn) begin
            m_seen = '0;
            m_ever = '{0, 0};
        end else if (pau) begin
            m_seen = '0;
        end else begin
            // objects: 0 flipper, 1 obstacle, 2 spring, 3 bumper, 4 frame
            for (int k = 0; k < 5; k++) hit[k] = d[0] & d[k+1];
            for (int p = 0; p < 2; p++) begin
                first   = sof || !m_seen[p+2];
                allowed = !m_ever[p] || ((m_frame - m_last[p]) >= m_hold[p]);
                if (hit[p+2] && first && allowed) begin
                    e[3+p]    = 1'b1;
                    m_ever[p] = 1'b1;
                    m_last[p] = sof ? m_frame + 1 : m_frame;
                end
            end
            for (int k = 0; k < 5; k++) begin
                if (hit[k])   m_seen[k] = 1'b1;
                else if (sof) m_seen[k] = 1'b0;
            end
            e[0] = m_seen[0];
            e[1] = m_seen[1];
            e[2] = m_seen[4];
            if (sof) m_frame++;
        end
        exp_q.push_back(e);
    endtask

    // One frame: strobe on cycle 0, overlap of 'mask' over [ostart, ostart+olen).
    task automatic frame(input int len, input int ostart, input int olen,
                         input logic [5:0] mask, input logic pau);
        for (int c = 0; c < len; c++) begin
            tick(((c >= ostart) && (c < ostart + olen)) ? mask : 6'h00, c == 0, pau, 1'b1);
        end
    endtask

    // Let the monitor consume the entry of the most recent tick.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Scoreboard monitor: compares the registered outputs once per cycle.
    always @(posedge clk) begin
        logic [4:0] e;
        logic [4:0] g;
        #1;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {collisionSmileyBumperPulse, collisionSmileySpringPulse,
                 collisionSmileyFrame, collisionSmileyObstacle, collisionSmileyFlipper};
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL scoreboard cycle %0d: got %b, expected %b", cyc, g, e);
            end
            if (collisionSmileySpringPulse === 1'b1) spring_pulses++;
            if (collisionSmileyBumperPulse === 1'b1) bumper_pulses++;
        end
    end

    initial begin
        int base;
        int hold_before;

        // Reset with every draw input active.
        tick(6'h3F, 1'b0, 1'b0, 1'b0);
        settle();
        check("reset_spring_holdoff", int'(dut.u_spring.g_pulse.holdoff_q), 0);
        check("reset_bumper_holdoff", int'(dut.u_bumper.g_pulse.holdoff_q), 0);

        // Single flipper pixel at cycle 100, frame strobe at cycle 500.
        for (int c = 1; c < 100; c++) tick(6'h00, 1'b0, 1'b0, 1'b1);
        tick(6'h03, 1'b0, 1'b0, 1'b1);
        settle();
        check("flipper_level_set", int'(collisionSmileyFlipper), 1);
        for (int c = 101; c < 500; c++) tick(6'h00, 1'b0, 1'b0, 1'b1);
        check("flipper_level_held", int'(collisionSmileyFlipper), 1);
        tick(6'h00, 1'b1, 1'b0, 1'b1);
        settle();
        check("flipper_level_cleared", int'(collisionSmileyFlipper), 0);

        // Spring overlap of 5 pixels in each of 17 frames: pulses in 0, 8, 16.
        tick(6'h00, 1'b0, 1'b0, 1'b0);
        base = spring_pulses;
        for (int f = 0; f < 17; f++) frame(20, 5, 5, 6'h09, 1'b0);
        settle();
        check("spring_pulse_count", spring_pulses - base, 3);

        // Obstacle hit coincident with the frame strobe survives into new frame.
        frame(10, 4, 1, 6'h05, 1'b0);
        frame(10, 0, 1, 6'h05, 1'b0);
        settle();
        check("obstacle_sof_set_wins", int'(collisionSmileyObstacle), 1);

        // Pause during bumper overlap: no pulse, outputs low, holdoff frozen.
        tick(6'h00, 1'b0, 1'b0, 1'b0);
        frame(12, 3, 4, 6'h11, 1'b0);
        settle();
        hold_before = int'(dut.u_bumper.g_pulse.holdoff_q);
        check("bumper_holdoff_loaded", hold_before, c_H_BUMPER);
        base = bumper_pulses;
        for (int f = 0; f < 3; f++) frame(12, 2, 6, 6'h3F, 1'b1);
        settle();
        check("pause_no_pulse", bumper_pulses - base, 0);
        check("pause_holdoff_frozen", int'(dut.u_bumper.g_pulse.holdoff_q), hold_before);
        check("pause_level_low", int'(collisionSmileyFlipper | collisionSmileyFrame), 0);
        for (int f = 0; f < 4; f++) frame(12, 3, 4, 6'h11, 1'b0);
        settle();
        check("unpause_pulse_after_holdoff", bumper_pulses - base, 1);

        // Bumper pulse in frame 0; reset in frame 1 clears the holdoff.
        tick(6'h00, 1'b0, 1'b0, 1'b0);
        base = bumper_pulses;
        frame(12, 3, 2, 6'h11, 1'b0);
        tick(6'h00, 1'b1, 1'b0, 1'b1);
        tick(6'h00, 1'b0, 1'b0, 1'b0);
        tick(6'h00, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) tick(6'h11, 1'b0, 1'b0, 1'b1);
        settle();
        check("reset_aborts_holdoff", bumper_pulses - base, 2);

        // Randomized frames against the model.
        for (int f = 0; f < 60; f++) begin
            int   len;
            logic pf;
            len = 8 + int'($urandom_range(0, 16));
            pf  = ($urandom_range(0, 9) == 0);
            for (int c = 0; c < len; c++) begin
                logic [5:0] d;
                logic       rn;
                logic       pc;
                d     = 6'($urandom);
                d[0]  = ($urandom_range(0, 3) != 0);
                rn    = ($urandom_range(0, 99) != 0);
                pc    = pf | ($urandom_range(0, 29) == 0);
                tick(d, c == 0, pc, rn);
            end
        end
        tick(6'h00, 1'b0, 1'b0, 1'b1);
        settle();
        settle();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ball_collision_detector
`default_nettype wire
